// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over req/ack and hands them to decode over valid/ready.
// Optional performance counters are compiled in with IFETCH_PERF_CNT_EN.
//
// state        | meaning
// REQ_WAIT_RST | idle cycle after reset release
// REQ          | imem_req high, waiting for imem_ack (bounded by MAX_WAIT)
// HOLD         | instruction presented, waiting for instr_ready
// HALT         | sticky stop; only reset leaves
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
`ifdef IFETCH_PERF_CNT_EN
  ,
  parameter int unsigned CNT_WIDTH = 32
`endif
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        imem_invalid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus_4,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        halted,
`ifdef IFETCH_PERF_CNT_EN
  output logic [CNT_WIDTH-1:0] perf_fetched,
  output logic [CNT_WIDTH-1:0] perf_redirects,
`endif
  output logic [1:0]  halt_cause
);

  typedef enum logic [1:0] {
    S_REQ_WAIT_RST = 2'd0,
    S_REQ          = 2'd1,
    S_HOLD         = 2'd2,
    S_HALT         = 2'd3
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state;
  state_t      next_state;
  logic [31:0] pc;
  logic [7:0]  wait_cnt;
  logic        misaligned;
  logic        consume;

  assign misaligned = redirect && (redirect_target[1:0] != 2'b00);
  assign consume    = (state == S_HOLD) && instr_ready;
  assign imem_addr  = pc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_REQ_WAIT_RST;
    else          state <= next_state;
  end

  // An ack always beats a timeout landing in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      S_REQ_WAIT_RST: next_state = S_REQ;
      S_REQ: begin
        if (imem_ack)                   next_state = imem_invalid ? S_HALT : S_HOLD;
        else if (wait_cnt == WAIT_LAST) next_state = S_HALT;
      end
      S_HOLD: begin
        if (instr_ready) next_state = misaligned ? S_HALT : S_REQ;
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_REQ_WAIT_RST;
    endcase
  end

  always_comb begin
    imem_req    = (state == S_REQ);
    instr_valid = (state == S_HOLD);
    halted      = (state == S_HALT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc              <= RESET_PC;
      wait_cnt        <= 8'd0;
      instr           <= 32'd0;
      instr_pc        <= 32'd0;
      instr_pc_plus_4 <= 32'd0;
      halt_cause      <= 2'b00;
    end else begin
      case (state)
        S_REQ: begin
          if (imem_ack) begin
            if (imem_invalid) begin
              halt_cause <= 2'b01;
            end else begin
              instr           <= imem_rdata;
              instr_pc        <= pc;
              instr_pc_plus_4 <= pc + 32'd4;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt == WAIT_LAST) halt_cause <= 2'b11;
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            if (misaligned) begin
              halt_cause <= 2'b10;
            end else begin
              pc       <= redirect ? redirect_target : pc + 32'd4;
              wait_cnt <= 8'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  // Counters only move in HOLD, so they freeze naturally once halted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched   <= '0;
      perf_redirects <= '0;
    end else if (consume) begin
      if (perf_fetched != '1) perf_fetched <= perf_fetched + 1'b1;
      if (redirect && !misaligned && (perf_redirects != '1))
        perf_redirects <= perf_redirects + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: behavioural memory, scoreboard of expected fetched PCs.
module tb_instr_fetch_unit;

  logic        clock;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_invalid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus_4;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        halted;
  logic [1:0]  halt_cause;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_redirects;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // memory model knobs
  logic [7:0]  wseen;
  int          ack_delay;
  int          cur_delay;
  bit          ack_en;
  bit          invalid_en;
  logic [31:0] invalid_addr;

  // redirect knobs
  bit          redir_en;
  logic [31:0] ra_from, ra_to, rb_from, rb_to;

  instr_fetch_unit dut (
    .clock(clock),
    .reset_n(reset_n),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .imem_invalid(imem_invalid),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_pc_plus_4(instr_pc_plus_4),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect(redirect),
    .redirect_target(redirect_target),
    .halted(halted),
`ifdef IFETCH_PERF_CNT_EN
    .perf_fetched(perf_fetched),
    .perf_redirects(perf_redirects),
`endif
    .halt_cause(halt_cause)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h1357, ~a[31:16]};
  endfunction

  assign imem_invalid    = invalid_en && (imem_addr == invalid_addr);
  // the undefined word answers late so its ack lands in the timeout cycle
  assign cur_delay       = imem_invalid ? 14 : ack_delay;
  assign imem_ack        = imem_req && ack_en && (int'(wseen) >= cur_delay);
  assign imem_rdata      = word_of(imem_addr);
  assign redirect        = redir_en && instr_valid && (instr_pc == ra_from || instr_pc == rb_from);
  assign redirect_target = (instr_pc == ra_from) ? ra_to : rb_to;

  always @(posedge clock) wseen <= (imem_req && !imem_ack) ? wseen + 8'd1 : 8'd0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    redir_en    = 1'b0;
    ack_en      = 1'b1;
    ack_delay   = 0;
    invalid_en  = 1'b0;
    instr_ready = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  // scoreboard: compare every consumed instruction against the next expected PC
  always @(negedge clock) begin
    if (reset_n && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL sb_underflow observed_pc=%h expected=none", instr_pc);
      end else begin
        logic [31:0] epc;
        epc = exp_q.pop_front();
        check32("sb_instr_pc", instr_pc, epc);
        check32("sb_instr", instr, word_of(epc));
        check32("sb_pc_plus_4", instr_pc_plus_4, epc + 32'd4);
      end
    end
  end

  initial begin
    logic [31:0] exp_addr [5];
    bit          done;

    reset_n = 1'b0; instr_ready = 1'b1; ack_en = 1'b1; ack_delay = 0;
    invalid_en = 1'b0; invalid_addr = 32'h0; redir_en = 1'b0;
    ra_from = 32'hFFFF_FFF0; ra_to = 32'h0; rb_from = 32'hFFFF_FFF0; rb_to = 32'h0;
    #3;
    check1("rst_req", imem_req, 1'b0);
    check1("rst_valid", instr_valid, 1'b0);
    check1("rst_halted", halted, 1'b0);
    check32("rst_cause", 32'(halt_cause), 32'd0);
    check32("rst_instr", instr, 32'd0);
    check32("rst_instr_pc", instr_pc, 32'd0);
    check32("rst_addr", imem_addr, 32'd0);

    // A: sequential fetch, zero wait, two redirects, PC wrap
    do_reset();
    redir_en = 1'b1;
    ra_from = 32'h8;  ra_to = 32'h40;
    rb_from = 32'h40; rb_to = 32'hFFFF_FFFC;
    exp_addr = '{32'h0, 32'h4, 32'h8, 32'h40, 32'hFFFF_FFFC};
    foreach (exp_addr[i]) exp_q.push_back(exp_addr[i]);
    check1("a_idle_req", imem_req, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step();
      check1("a_valid_pattern", instr_valid, (i % 2) == 0);
      if (i % 2 == 1) begin
        check1("a_req", imem_req, 1'b1);
        check32("a_addr", imem_addr, exp_addr[(i - 1) / 2]);
      end
    end
    step();
    check1("a_wrap_req", imem_req, 1'b1);
    check32("a_wrap_addr", imem_addr, 32'h0);
    check32("a_sb_empty", 32'(exp_q.size()), 32'd0);
`ifdef IFETCH_PERF_CNT_EN
    check32("a_perf_fetched", perf_fetched, 32'd5);
    check32("a_perf_redirects", perf_redirects, 32'd2);
`endif

    // B: ack after 3 waits, ready stall, ack on last allowed cycle, then timeout
    do_reset();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    ack_delay = 3;
    instr_ready = 1'b0;
    step();
    for (int k = 1; k <= 4; k++) begin
      check1("b_req_stable", imem_req, 1'b1);
      check32("b_addr_stable", imem_addr, 32'h0);
      check1("b_no_halt", halted, 1'b0);
      step();
    end
    check1("b_valid", instr_valid, 1'b1);
    repeat (2) step();
    check1("b_stall_valid", instr_valid, 1'b1);
    check32("b_stall_instr", instr, word_of(32'h0));
    ack_delay = 14;
    instr_ready = 1'b1;
    step();
    for (int k = 1; k <= 15; k++) step();
    check1("b_last_cycle_ack", instr_valid, 1'b1);
    check1("b_last_cycle_nohalt", halted, 1'b0);
    ack_en = 1'b0;
    step();
    for (int k = 1; k <= 15; k++) begin
      if (k == 15) begin
        check1("b_pre_timeout_req", imem_req, 1'b1);
        check1("b_pre_timeout_halt", halted, 1'b0);
      end
      step();
    end
    check1("b_timeout_halted", halted, 1'b1);
    check32("b_timeout_cause", 32'(halt_cause), 32'd3);
    check1("b_timeout_req", imem_req, 1'b0);
    check32("b_sb_empty", 32'(exp_q.size()), 32'd0);

    // C: undefined word at 0x20, acked in the timeout cycle
    do_reset();
    invalid_en = 1'b1;
    invalid_addr = 32'h20;
    for (int a = 0; a < 32'h20; a += 4) exp_q.push_back(32'(a));
    done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      step();
      if (halted) done = 1'b1;
    end
    check1("c_halt_reached", done, 1'b1);
    check32("c_cause", 32'(halt_cause), 32'd1);
    check1("c_valid", instr_valid, 1'b0);
    check32("c_last_pc", instr_pc, 32'h1C);
    check32("c_sb_empty", 32'(exp_q.size()), 32'd0);
    repeat (3) step();
    check1("c_req_after", imem_req, 1'b0);
    check32("c_cause_sticky", 32'(halt_cause), 32'd1);

    // D: misaligned redirect target
    do_reset();
    redir_en = 1'b1;
    ra_from = 32'h0; ra_to = 32'h102;
    exp_q.push_back(32'h0);
    repeat (3) step();
    check1("d_halted", halted, 1'b1);
    check32("d_cause", 32'(halt_cause), 32'd2);
    check1("d_req", imem_req, 1'b0);
    check32("d_pc_kept", imem_addr, 32'h0);
    repeat (2) step();
`ifdef IFETCH_PERF_CNT_EN
    check32("d_perf_fetched", perf_fetched, 32'd1);
    check32("d_perf_redirects", perf_redirects, 32'd0);
`endif
    check32("d_sb_empty", 32'(exp_q.size()), 32'd0);

    // E: async reset in the middle of a pending request
    do_reset();
    exp_q.push_back(32'h0);
    repeat (2) step();
    ack_en = 1'b0;
    repeat (2) step();
    check1("e_pending_req", imem_req, 1'b1);
    check32("e_pending_addr", imem_addr, 32'h4);
    #2 reset_n = 1'b0;
    #1;
    check1("e_rst_req", imem_req, 1'b0);
    check32("e_rst_instr", instr, 32'd0);
    check32("e_rst_instr_pc", instr_pc, 32'd0);
    check32("e_rst_plus_4", instr_pc_plus_4, 32'd0);
    check32("e_rst_addr", imem_addr, 32'h0);
    check1("e_rst_valid", instr_valid, 1'b0);
    ack_en = 1'b1;
    @(posedge clock);
    #1 reset_n = 1'b1;
    check1("e_idle_req", imem_req, 1'b0);
    step();
    check1("e_restart_req", imem_req, 1'b1);
    check32("e_restart_addr", imem_addr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream fetch stage for the MIPS core. Owns the architectural PC and issues word requests to instruction memory over a req/ack handshake.
- Presents the fetched instruction, its PC and PC+4 to the decode/execute datapath through a valid/ready handshake.
- Applies jump/branch/jr redirects returned by the datapath.
- Enters a sticky halt on an undefined instruction word, a misaligned target or a memory timeout.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- MAX_WAIT, 15, max cycles imem_req may stay unacknowledged before timeout halt (1..255).
- CNT_WIDTH, 32, width of performance counters (optional feature only).

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  byte address of requested word (= pc)
- imem_ack  in  1  memory has returned imem_rdata this cycle
- imem_rdata  in  32  instruction word
- imem_invalid  in  1  with ack: addressed word undefined (end of program)
- instr  out  32  captured instruction
- instr_pc  out  32  PC of instr
- instr_pc_plus_4  out  32  instr_pc + 4, for jal link and branch target
- instr_valid  out  1  instr/instr_pc valid
- instr_ready  in  1  datapath consumes instr this cycle
- redirect  in  1  with consumption: next PC is redirect_target
- redirect_target  in  32  jump/branch/jr target
- halted  out  1  sticky halt flag
- halt_cause  out  2  00 none, 01 invalid word, 10 misaligned target, 11 timeout

Behaviour:
- Reset (async, immediate on reset_n low):
  - pc=RESET_PC, state=REQ_WAIT_RST, wait_cnt=0.
  - imem_req=0, instr=0, instr_pc=0, instr_pc_plus_4=0, instr_valid=0, halted=0, halt_cause=00.
- States: REQ_WAIT_RST, REQ, HOLD, HALT.
- REQ_WAIT_RST: one idle cycle after reset release, then REQ.
- REQ:
  - imem_req=1, imem_addr=pc; both held stable until ack.
  - Ack with imem_invalid=1: -> HALT, cause 01, instr_valid stays 0.
  - Ack with imem_invalid=0: capture instr<=imem_rdata, instr_pc<=pc, instr_pc_plus_4<=pc+4; instr_valid=1 next cycle; -> HOLD.
  - Zero-wait ack (same cycle req rises) is legal.
  - wait_cnt increments each REQ cycle without ack. Reaching MAX_WAIT with no ack: -> HALT, cause 11.
- HOLD:
  - instr_valid=1; instr and both PC outputs stable.
  - On instr_ready=1: pc<=redirect ? redirect_target : pc+4; instr_valid<=0; wait_cnt<=0; -> REQ.
  - If redirect=1 and redirect_target[1:0]!=0: -> HALT, cause 10; pc not updated.
- redirect and redirect_target are sampled only in a HOLD cycle with instr_ready=1; ignored at all other times.
- imem_ack outside REQ is ignored.
- Throughput: best case one instruction per 2 cycles (REQ with ack, HOLD with ready).
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0); wrap is not an error.
- HALT:
  - imem_req=0, instr_valid=0, halted=1, halt_cause holds the first cause.
  - Only reset exits HALT.
- Simultaneous events:
  - Ack with invalid in the timeout cycle: cause 01 wins.
  - Reset overrides everything, including mid-handshake. imem_req drops combinationally-from-register on reset assertion; the memory must discard the in-flight request.

Optional Feature:
- Macro IFETCH_PERF_CNT_EN.
- When defined, adds outputs perf_fetched [CNT_WIDTH] and perf_redirects [CNT_WIDTH].
  - perf_fetched increments on each consumed instruction (HOLD & instr_ready).
  - perf_redirects increments on each consumed instruction with redirect=1 and an aligned target.
  - Both are cleared by reset, saturate at all-ones, and freeze in HALT.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Sequential fetch, zero-wait memory, ready always 1 -> imem_addr 0,4,8,12 on successive REQ cycles; instr_valid every 2nd cycle; instr_pc_plus_4 = instr_pc+4.
- Instruction at 8, redirect=1, target=32'h40 on consumption -> next imem_addr=32'h40; no request to 12.
- Ack delayed 3 cycles, MAX_WAIT=15 -> imem_req/addr stable 4 cycles, no halt. Ack withheld 15 cycles -> halted=1, cause=11.
- Ack with imem_invalid=1 at address 32'h20 -> halted=1, cause=01, instr_valid never rises, imem_req=0 thereafter.
- Redirect target 32'h102 -> halted=1, cause=10; reset_n pulsed low mid-REQ -> all outputs at reset values immediately, fetch restarts at RESET_PC two cycles after release.
- With IFETCH_PERF_CNT_EN: 5 consumed instructions, 2 redirects -> perf_fetched=5, perf_redirects=2.
